// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy/fill engine: FSM encoding, operation
// modes and the supported memory read latencies.
package mem_copy_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RWAIT,
    S_WR,
    S_DONE
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

  function automatic bit rd_latency_legal(input int lat);
    return (lat == RD_LAT_COMB) || (lat == RD_LAT_REG);
  endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy / fill initiator for a single-port memory. Every output is a
// register loaded from the next-state decode, so the memory sees glitch-free controls.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                  r_state;
  logic                    r_mode;
  logic [ADDR_WIDTH-1:0]   r_src;
  logic [ADDR_WIDTH-1:0]   r_dst;
  logic [ADDR_WIDTH:0]     r_len;
  logic [DATA_WIDTH-1:0]   r_fill;
  logic [ADDR_WIDTH:0]     r_words_done;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;

  state_e                  w_state_nxt;
  state_e                  w_after_rd;
  logic                    w_capture_in_rd;
  logic                    w_mode_nxt;
  logic [ADDR_WIDTH-1:0]   w_src_nxt;
  logic [ADDR_WIDTH-1:0]   w_dst_nxt;
  logic [ADDR_WIDTH:0]     w_len_nxt;
  logic [DATA_WIDTH-1:0]   w_fill_nxt;
  logic [ADDR_WIDTH:0]     w_words_nxt;
  logic [ADDR_WIDTH:0]     w_words_inc;
  logic [ADDR_WIDTH-1:0]   w_addr_nxt;
  logic [DATA_WIDTH-1:0]   w_wdata_nxt;

  // A registered-read memory needs one extra cycle before its data is valid.
  if (!rd_latency_legal(RD_LATENCY)) begin : g_rd_bad
    $error("mem_copy_engine: RD_LATENCY must be 0 or 1");
  end

  if (RD_LATENCY == RD_LAT_REG) begin : g_rd_reg
    assign w_after_rd      = S_RWAIT;
    assign w_capture_in_rd = 1'b0;
  end else begin : g_rd_comb
    assign w_after_rd      = S_WR;
    assign w_capture_in_rd = 1'b1;
  end

  assign w_words_inc = r_words_done + COUNT_ONE;

  always_comb begin
    // NOTE: every target gets a default before the case so no path can infer a latch.
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_len_nxt   = r_len;
    w_fill_nxt  = r_fill;
    w_words_nxt = r_words_done;
    w_wdata_nxt = r_mem_wdata;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mode_nxt  = mode;
          w_src_nxt   = src_addr;
          w_dst_nxt   = dst_addr;
          w_len_nxt   = length;
          w_fill_nxt  = fill_value;
          w_words_nxt = '0;
          if (length == '0) begin
            w_state_nxt = S_DONE;
          end else if (mode == MODE_FILL) begin
            w_state_nxt = S_WR;
            w_wdata_nxt = fill_value;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        w_state_nxt = w_after_rd;
        if (w_capture_in_rd) w_wdata_nxt = mem_rdata;
      end
      S_RWAIT: begin
        w_state_nxt = S_WR;
        w_wdata_nxt = mem_rdata;
      end
      S_WR: begin
        w_src_nxt   = r_src + ADDR_ONE;
        w_dst_nxt   = r_dst + ADDR_ONE;
        w_words_nxt = w_words_inc;
        if (w_words_inc == r_len) begin
          w_state_nxt = S_DONE;
        end else if (r_mode == MODE_FILL) begin
          w_state_nxt = S_WR;
          w_wdata_nxt = r_fill;
        end else begin
          w_state_nxt = S_RD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // RWAIT, DONE and IDLE keep the last address on the bus.
  always_comb begin
    unique case (w_state_nxt)
      S_RD:    w_addr_nxt = w_src_nxt;
      S_WR:    w_addr_nxt = w_dst_nxt;
      default: w_addr_nxt = r_mem_addr;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the async reset also
  // drops mem_we the instant rst rises, abandoning any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mode       <= MODE_COPY;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_fill       <= '0;
      r_words_done <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_src        <= w_src_nxt;
      r_dst        <= w_dst_nxt;
      r_len        <= w_len_nxt;
      r_fill       <= w_fill_nxt;
      r_words_done <= w_words_nxt;
      r_busy       <= (w_state_nxt == S_RD) || (w_state_nxt == S_RWAIT) || (w_state_nxt == S_WR);
      r_done       <= (w_state_nxt == S_DONE);
      r_mem_we     <= (w_state_nxt == S_WR);
      r_mem_addr   <= w_addr_nxt;
      r_mem_wdata  <= w_wdata_nxt;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign words_done = r_words_done;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: one engine per legal read latency, each driving its own
// behavioural memory, compared against a word-by-word reference model.
module tb_mem_copy_engine;
  import mem_copy_engine_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          rst_v;
  logic [1:0]          start_v;
  logic                mode_i;
  logic [AW-1:0]       src_i, dst_i;
  logic [AW:0]         len_i;
  logic [DW-1:0]       fill_i;
  logic [1:0]          busy_v, done_v, we_v;
  logic [1:0][AW:0]    wd_v;
  logic [1:0][AW-1:0]  addr_v;
  logic [1:0][DW-1:0]  wdata_v;
  logic [DW-1:0]       rdata0, rdata1;

  logic [DW-1:0] mem     [2][NW];
  logic [DW-1:0] ref_mem [2][NW];

  logic          pre_we;
  int            pre_sel;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int total = 0;
  int bad   = 0;

  mem_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .mode(mode_i),
    .src_addr(src_i), .dst_addr(dst_i), .length(len_i), .fill_value(fill_i),
    .busy(busy_v[0]), .done(done_v[0]), .words_done(wd_v[0]),
    .mem_we(we_v[0]), .mem_addr(addr_v[0]), .mem_wdata(wdata_v[0]), .mem_rdata(rdata0)
  );

  mem_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .mode(mode_i),
    .src_addr(src_i), .dst_addr(dst_i), .length(len_i), .fill_value(fill_i),
    .busy(busy_v[1]), .done(done_v[1]), .words_done(wd_v[1]),
    .mem_we(we_v[1]), .mem_addr(addr_v[1]), .mem_wdata(wdata_v[1]), .mem_rdata(rdata1)
  );

  // Responders: memory 0 reads combinationally, memory 1 through a register.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we_v[d]) mem[d][addr_v[d]] <= wdata_v[d];
      else if (pre_we && pre_sel == d) mem[d][pre_addr] <= pre_data;
    end
  end
  assign rdata0 = mem[0][addr_v[0]];
  always @(posedge clk) rdata1 <= mem[1][addr_v[1]];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_word(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_sel  = d;
    pre_addr = a;
    pre_data = v;
    pre_we   = 1'b1;
    ref_mem[d][a] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_mem(input int d, input string tag);
    int diffs = 0;
    for (int a = 0; a < NW; a++)
      if (mem[d][a] !== ref_mem[d][a]) diffs++;
    check(tag, diffs, 0);
  endtask

  // Runs one operation on engine d and checks timing, write trace and memory.
  task automatic run_op(input int d, input logic m, input logic [AW-1:0] s,
                        input logic [AW-1:0] ds, input int len,
                        input logic [DW-1:0] fv, input bit collide);
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    logic [AW-1:0] sa, da;
    int exp_busy, exp_done, budget;
    int busy_n = 0, done_n = 0, done_cyc = -1, we_n = 0, trace_bad = 0, wd_at_done = -1;
    for (int i = 0; i < len; i++) begin
      sa = s + AW'(i);
      da = ds + AW'(i);
      ref_mem[d][da] = m ? fv : ref_mem[d][sa];
      exp_a.push_back(da);
      exp_d.push_back(ref_mem[d][da]);
    end
    exp_busy = m ? len : len * (2 + d);
    exp_done = exp_busy + 1;
    budget   = exp_done + 4;

    mode_i = m; src_i = s; dst_i = ds; len_i = len[AW:0]; fill_i = fv;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (busy_v[d]) busy_n++;
      if (done_v[d]) begin
        done_n++;
        if (done_cyc < 0) begin
          done_cyc   = c;
          wd_at_done = int'(wd_v[d]);
          check("we_at_done", int'(we_v[d]), 0);
        end
      end
      if (we_v[d]) begin
        if (we_n >= exp_a.size()) trace_bad++;
        else if (addr_v[d] !== exp_a[we_n] || wdata_v[d] !== exp_d[we_n]) trace_bad++;
        we_n++;
      end
      if (collide && c == 2) begin
        mode_i = ~m; src_i = ~s; dst_i = ~ds; len_i = 9'd1; fill_i = ~fv;
        start_v[d] = 1'b1;
      end else begin
        start_v[d] = 1'b0;
      end
      @(negedge clk);
    end
    check("done_cycle", done_cyc, exp_done);
    check("done_count", done_n, 1);
    check("busy_cycles", busy_n, exp_busy);
    check("we_cycles", we_n, len);
    check("write_trace", trace_bad, 0);
    check("words_done", wd_at_done, len);
    check_mem(d, "mem_image");
  endtask

  task automatic reset_mid_copy(input int d);
    logic [AW-1:0] s = 8'h40, ds = 8'h80;
    int we_n = 0, dn = 0;
    bit hit = 1'b0;
    mode_i = MODE_COPY; src_i = s; dst_i = ds; len_i = 9'd4; fill_i = '0;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      if (we_v[d]) we_n++;
      if (we_n == 2) hit = 1'b1;
      else @(negedge clk);
    end
    check("reach_second_wr", int'(hit), 1);
    rst_v[d] = 1'b1;
    #1;
    check("rst_we_drop", int'(we_v[d]), 0);
    check("rst_outs_zero", int'(|{busy_v[d], done_v[d], wd_v[d], addr_v[d], wdata_v[d]}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_v[d] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done_v[d]) dn++;
      @(negedge clk);
    end
    check("rst_no_done", dn, 0);
    ref_mem[d][ds] = ref_mem[d][s];
    check_mem(d, "rst_mem_image");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_v = 2'b11; start_v = 2'b00; pre_we = 1'b0; pre_sel = 0;
    pre_addr = '0; pre_data = '0;
    mode_i = 1'b0; src_i = '0; dst_i = '0; len_i = '0; fill_i = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_busy", int'(busy_v[d]), 0);
      check("reset_done", int'(done_v[d]), 0);
      check("reset_we", int'(we_v[d]), 0);
      check("reset_words", int'(wd_v[d]), 0);
      check("reset_addr", int'(addr_v[d]), 0);
      check("reset_wdata", int'(wdata_v[d]), 0);
    end
    rst_v = 2'b00;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < NW; a++) load_word(d, AW'(a), DW'($urandom));

      run_op(d, MODE_FILL, 8'h00, 8'h10, 4, 8'hA5, 1'b0);
      for (int i = 0; i < 4; i++) check("fill_readback", int'(mem[d][16 + i]), 8'hA5);

      load_word(d, 8'd5, 8'd45); load_word(d, 8'd6, 8'd77); load_word(d, 8'd7, 8'd32);
      run_op(d, MODE_COPY, 8'd5, 8'd20, 3, 8'h00, 1'b0);
      check("copy_w20", int'(mem[d][20]), 45);
      check("copy_w21", int'(mem[d][21]), 77);
      check("copy_w22", int'(mem[d][22]), 32);

      run_op(d, MODE_COPY, 8'h33, 8'h44, 0, 8'h00, 1'b0);

      run_op(d, MODE_FILL, 8'h00, 8'hFE, 3, 8'h3C, 1'b0);
      check("wrap_wFE", int'(mem[d][254]), 8'h3C);
      check("wrap_wFF", int'(mem[d][255]), 8'h3C);
      check("wrap_w00", int'(mem[d][0]), 8'h3C);

      load_word(d, 8'd0, 8'd1); load_word(d, 8'd1, 8'd2); load_word(d, 8'd2, 8'd3);
      run_op(d, MODE_COPY, 8'd0, 8'd1, 2, 8'h00, 1'b1);
      check("overlap_w1", int'(mem[d][1]), 1);
      check("overlap_w2", int'(mem[d][2]), 1);

      reset_mid_copy(d);
      run_op(d, MODE_COPY, 8'h60, 8'hA0, 5, 8'h00, 1'b0);

      run_op(d, MODE_FILL, 8'h00, DW'($urandom), 256, DW'($urandom), 1'b0);
      run_op(d, MODE_COPY, DW'($urandom), DW'($urandom), 256, 8'h00, 1'b0);

      for (int k = 0; k < 15; k++) begin
        int len;
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 24));
        run_op(d, logic'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), len,
               DW'($urandom), bit'($urandom_range(0, 1)) && len > 2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
